// File: rtl/pcs_block_sync_pkg.sv
// Shared constants and types for the 66b receive block-lock logic.
// Header encodings, lock FSM states and default window sizes.
package pcs_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int SH_CNT_MAX_DEF     = 64;
    localparam int SH_INVALID_MAX_DEF = 16;
    localparam int SLIP_WAIT_DEF      = 32;
    localparam int CNT_WIDTH_DEF      = 16;

    typedef enum logic [1:0] {
        RESET_CNT,
        TEST,
        SLIP,
        WAIT
    } lock_state_e;

    function automatic logic sh_valid(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/pcs_block_sync_if.sv
// Gearbox-to-PCS header stream plus block-lock status and counters.
// master drives headers (gearbox side), slave is the lock controller.
interface pcs_block_sync_if #(
    parameter int CNT_WIDTH = 16
);

    logic [1:0]           rx_pcs_header;
    logic                 rx_pcs_valid;
    logic                 rx_slip;
    logic                 rx_block_lock;
    logic                 rx_pcs_valid_locked;
    logic [CNT_WIDTH-1:0] rx_slip_count;
    logic [CNT_WIDTH-1:0] rx_lock_loss_count;

    modport master (
        output rx_pcs_header,
        output rx_pcs_valid,
        input  rx_slip,
        input  rx_block_lock,
        input  rx_pcs_valid_locked,
        input  rx_slip_count,
        input  rx_lock_loss_count
    );

    modport slave (
        input  rx_pcs_header,
        input  rx_pcs_valid,
        output rx_slip,
        output rx_block_lock,
        output rx_pcs_valid_locked,
        output rx_slip_count,
        output rx_lock_loss_count
    );

endinterface

// File: rtl/pcs_block_sync_sat_counter.sv
// Saturating up-counter used for the block-lock status counts.
// Holds at all-ones instead of wrapping.
module pcs_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pcs_block_sync.sv
// 66b block-lock controller: tests sync headers, slips the gearbox
// until alignment holds for a full window, then declares lock.
module pcs_block_sync
    import pcs_pkg::*;
#(
    parameter int SH_CNT_MAX     = SH_CNT_MAX_DEF,
    parameter int SH_INVALID_MAX = SH_INVALID_MAX_DEF,
    parameter int SLIP_WAIT      = SLIP_WAIT_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic             pcs_clk,
    input  logic             pcs_rst,
    pcs_block_sync_if.slave  bus
);

    localparam int SH_W = $clog2(SH_CNT_MAX + 1);
    localparam int IV_W = $clog2(SH_INVALID_MAX + 1);
    localparam int WT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0] SH_ONE = SH_W'(1);
    localparam logic [SH_W-1:0] SH_MAX = SH_W'(SH_CNT_MAX);
    localparam logic [IV_W-1:0] IV_ONE = IV_W'(1);
    localparam logic [IV_W-1:0] IV_MAX = IV_W'(SH_INVALID_MAX);
    localparam logic [WT_W-1:0] WT_ONE = WT_W'(1);
    localparam logic [WT_W-1:0] WT_MAX = WT_W'(SLIP_WAIT);

    lock_state_e     state_q, state_d;
    logic [SH_W-1:0] sh_cnt_q, sh_cnt_d, sh_nxt;
    logic [IV_W-1:0] inv_cnt_q, inv_cnt_d, inv_nxt;
    logic [WT_W-1:0] wait_q, wait_d;
    logic            lock_q, lock_d;
    logic            slip_q, slip_d;
    logic            slip_inc, loss_inc;
    logic            beat, hdr_ok;

    logic [CNT_WIDTH-1:0] slip_cnt, loss_cnt;

    assign beat   = bus.rx_pcs_valid;
    assign hdr_ok = sh_valid(bus.rx_pcs_header);
    assign sh_nxt  = sh_cnt_q + SH_ONE;
    assign inv_nxt = hdr_ok ? inv_cnt_q : inv_cnt_q + IV_ONE;

    always_ff @(posedge pcs_clk or posedge pcs_rst) begin
        if (pcs_rst) begin
            state_q   <= RESET_CNT;
            sh_cnt_q  <= '0;
            inv_cnt_q <= '0;
            wait_q    <= '0;
            lock_q    <= 1'b0;
            slip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_cnt_q  <= sh_cnt_d;
            inv_cnt_q <= inv_cnt_d;
            wait_q    <= wait_d;
            lock_q    <= lock_d;
            slip_q    <= slip_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_cnt_d  = sh_cnt_q;
        inv_cnt_d = inv_cnt_q;
        wait_d    = wait_q;
        unique case (state_q)
            RESET_CNT: begin
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
                state_d   = TEST;
            end
            TEST: begin
                if (beat) begin
                    sh_cnt_d  = sh_nxt;
                    inv_cnt_d = inv_nxt;
                    // Loss of lock outranks the end-of-window check.
                    if (!hdr_ok && (!lock_q || inv_nxt == IV_MAX)) begin
                        state_d = SLIP;
                    end else if (sh_nxt == SH_MAX) begin
                        state_d = RESET_CNT;
                    end
                end
            end
            SLIP: begin
                wait_d  = WT_MAX;
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q <= WT_ONE) begin
                    wait_d  = '0;
                    state_d = RESET_CNT;
                end else begin
                    wait_d = wait_q - WT_ONE;
                end
            end
            default: state_d = RESET_CNT;
        endcase
    end

    always_comb begin
        slip_inc = (state_q == TEST) && (state_d == SLIP);
        loss_inc = slip_inc && lock_q;
        slip_d   = slip_inc;
        lock_d   = lock_q;
        if (loss_inc) begin
            lock_d = 1'b0;
        end else if ((state_q == TEST) && beat &&
                     (sh_nxt == SH_MAX) && (inv_nxt == '0)) begin
            lock_d = 1'b1;
        end
    end

    pcs_sat_counter #(.WIDTH(CNT_WIDTH)) u_slip_cnt (
        .clk_i   (pcs_clk),
        .rst_i   (pcs_rst),
        .inc_i   (slip_inc),
        .count_o (slip_cnt)
    );

    pcs_sat_counter #(.WIDTH(CNT_WIDTH)) u_loss_cnt (
        .clk_i   (pcs_clk),
        .rst_i   (pcs_rst),
        .inc_i   (loss_inc),
        .count_o (loss_cnt)
    );

    assign bus.rx_slip             = slip_q;
    assign bus.rx_block_lock       = lock_q;
    assign bus.rx_pcs_valid_locked = bus.rx_pcs_valid & lock_q;
    assign bus.rx_slip_count       = slip_cnt;
    assign bus.rx_lock_loss_count  = loss_cnt;

endmodule

// File: tb/tb_pcs_block_sync.sv
// Directed bench for pcs_block_sync: acquisition, tolerance,
// lock loss, slip wait, toggling valid and async reset.
module tb_pcs_block_sync;
    import pcs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   slip_pulses = 0;

    always #5 clk = ~clk;

    pcs_block_sync_if #(.CNT_WIDTH(16)) bus ();

    pcs_block_sync #(
        .SH_CNT_MAX     (64),
        .SH_INVALID_MAX (16),
        .SLIP_WAIT      (32),
        .CNT_WIDTH      (16)
    ) dut (
        .pcs_clk (clk),
        .pcs_rst (rst),
        .bus     (bus)
    );

    always @(negedge clk) begin
        if (bus.rx_slip === 1'b1) slip_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] h, input logic v);
        bus.rx_pcs_header = h;
        bus.rx_pcs_valid  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input int n, input logic [1:0] h);
        repeat (n) cyc(h, 1'b1);
    endtask

    // Bad headers on beats 4,8,..,4*ninv; optionally also on beat 64.
    task automatic window(input int ninv, input bit last_bad);
        for (int p = 1; p <= 64; p++) begin
            bit bad;
            bad = ((p % 4 == 0) && (p / 4 <= ninv)) || (p == 64 && last_bad);
            cyc(bad ? 2'b11 : SH_DATA, 1'b1);
        end
    endtask

    initial begin
        bus.rx_pcs_header = 2'b00;
        bus.rx_pcs_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_lock", bus.rx_block_lock, 0);
        check("rst_slip", bus.rx_slip, 0);
        check("rst_slipcnt", bus.rx_slip_count, 0);
        check("rst_losscnt", bus.rx_lock_loss_count, 0);
        rst = 1'b0;

        // 1: clean acquisition
        cyc(SH_DATA, 1'b0);
        beats(63, SH_DATA);
        check("t1_lock_63", bus.rx_block_lock, 0);
        cyc(SH_CTRL, 1'b1);
        check("t1_lock_64", bus.rx_block_lock, 1);
        check("t1_vlock", bus.rx_pcs_valid_locked, 1);
        check("t1_slipcnt", bus.rx_slip_count, 0);
        check("t1_pulses", slip_pulses, 0);

        // 3: 15 bad headers per window, three windows
        cyc(SH_DATA, 1'b0);
        repeat (3) begin
            window(15, 1'b0);
            check("t3_lock", bus.rx_block_lock, 1);
            cyc(SH_DATA, 1'b0);
        end
        check("t3_pulses", slip_pulses, 0);
        check("t3_losscnt", bus.rx_lock_loss_count, 0);

        // 4: 16th bad header on beat 64
        window(15, 1'b1);
        check("t4_lock", bus.rx_block_lock, 0);
        check("t4_slip", bus.rx_slip, 1);
        check("t4_losscnt", bus.rx_lock_loss_count, 1);
        check("t4_slipcnt", bus.rx_slip_count, 1);
        check("t4_vlock", bus.rx_pcs_valid_locked, 0);
        cyc(2'b11, 1'b1);
        check("t4_slip_off", bus.rx_slip, 0);
        repeat (32) cyc(2'b11, 1'b1);
        cyc(SH_DATA, 1'b0);
        check("t4_pulses", slip_pulses, 1);

        // 2: unlocked, bad header on beat 10, wait ignores headers
        beats(9, SH_DATA);
        cyc(2'b00, 1'b1);
        check("t2_slip", bus.rx_slip, 1);
        check("t2_slipcnt", bus.rx_slip_count, 2);
        repeat (33) cyc(2'b00, 1'b1);
        cyc(SH_DATA, 1'b0);
        check("t2_slipcnt_wait", bus.rx_slip_count, 2);
        check("t2_pulses", slip_pulses, 2);
        beats(63, SH_DATA);
        check("t2_lock_63", bus.rx_block_lock, 0);
        cyc(SH_DATA, 1'b1);
        check("t2_lock_64", bus.rx_block_lock, 1);

        // 6a: async reset while locked
        #2 rst = 1'b1;
        #1;
        check("t6a_lock", bus.rx_block_lock, 0);
        check("t6a_vlock", bus.rx_pcs_valid_locked, 0);
        check("t6a_slipcnt", bus.rx_slip_count, 0);
        check("t6a_losscnt", bus.rx_lock_loss_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 6b: async reset mid-wait
        cyc(SH_DATA, 1'b0);
        beats(5, SH_DATA);
        cyc(2'b11, 1'b1);
        check("t6b_slip", bus.rx_slip, 1);
        check("t6b_slipcnt", bus.rx_slip_count, 1);
        repeat (10) cyc(2'b11, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6b_slipcnt_rst", bus.rx_slip_count, 0);
        check("t6b_slip_rst", bus.rx_slip, 0);
        check("t6b_lock_rst", bus.rx_block_lock, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 5: valid toggling, idle beats carry bad headers
        cyc(SH_DATA, 1'b0);
        for (int i = 0; i < 63; i++) begin
            cyc(SH_DATA, 1'b1);
            cyc(2'b11, 1'b0);
        end
        check("t5_lock_63", bus.rx_block_lock, 0);
        cyc(SH_DATA, 1'b1);
        check("t5_lock_64", bus.rx_block_lock, 1);
        check("t5_vlock_on", bus.rx_pcs_valid_locked, 1);
        cyc(2'b11, 1'b0);
        check("t5_vlock_idle", bus.rx_pcs_valid_locked, 0);
        check("t5_lock_idle", bus.rx_block_lock, 1);
        check("t5_slipcnt", bus.rx_slip_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcs_block_sync.md
Name: pcs_block_sync

Overview:
- Receive-side 66b block-lock controller, per IEEE 802.3 Clause 49 lock state machine (simplified).
- Watches the 2-bit sync headers coming from the gearbox into the PCS.
- Commands gearbox bit-slips until header alignment is found, then declares block lock.
- Gates the valid qualifier into the descrambler/decoder path so only locked blocks reach the rx MAC.

Parameters:
SH_CNT_MAX, 64, headers per test window
SH_INVALID_MAX, 16, invalid headers within one window that cause loss of lock
SLIP_WAIT, 32, pcs_clk cycles to ignore headers after a slip pulse (gearbox settle time)
CNT_WIDTH, 16, width of status counters

Ports:
pcs_clk  in  1  PCS clock, single clock domain
pcs_rst  in  1  asynchronous, active-high reset
rx_pcs_header  in  2  sync header from gearbox
rx_pcs_valid  in  1  header/data beat valid from gearbox
rx_slip  out  1  one-cycle bit-slip request to gearbox
rx_block_lock  out  1  block lock status
rx_pcs_valid_locked  out  1  rx_pcs_valid AND rx_block_lock (combinational); drives descrambler/decoder valid
rx_slip_count  out  CNT_WIDTH  saturating count of slips issued
rx_lock_loss_count  out  CNT_WIDTH  saturating count of 1->0 transitions of rx_block_lock

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=RESET_CNT; sh_cnt=0, sh_invalid_cnt=0, wait_cnt=0; all registered outputs 0.
- Header valid: rx_pcs_header is 2'b01 or 2'b10. Header invalid: 2'b00 or 2'b11.
- Only cycles with rx_pcs_valid=1 are tested. rx_pcs_valid=0 leaves all counters and state unchanged.
- All decisions are registered. rx_block_lock, rx_slip and the counters update on the cycle after the deciding beat.
- States:
  - RESET_CNT: clear sh_cnt and sh_invalid_cnt. Go to TEST next cycle. No header is tested in this cycle.
  - TEST: each valid beat increments sh_cnt; an invalid header also increments sh_invalid_cnt. Evaluate with the post-increment values:
    - Invalid header, lock=0: go to SLIP.
    - Invalid header, lock=1, sh_invalid_cnt==SH_INVALID_MAX: lock<=0, lock_loss_count++, go to SLIP. This has priority over window end.
    - sh_cnt==SH_CNT_MAX and sh_invalid_cnt==0: lock<=1, go to RESET_CNT.
    - sh_cnt==SH_CNT_MAX and sh_invalid_cnt>0 (lock=1 only): go to RESET_CNT; lock stays 1.
    - Otherwise: stay in TEST.
  - SLIP:
    - rx_slip=1 for exactly one cycle; slip_count++.
    - Load wait_cnt=SLIP_WAIT, go to WAIT.
  - WAIT:
    - Decrement wait_cnt every cycle, regardless of rx_pcs_valid.
    - Headers are ignored.
    - At 0, go to RESET_CNT.
- Lock acquisition therefore requires SH_CNT_MAX consecutive valid headers from an unlocked state.
- Counters saturate at all-ones and never wrap.
- rx_slip is never asserted while rx_block_lock=1. Lock loss and the slip are decided on the same beat.
- pcs_rst mid-window or mid-WAIT immediately forces all outputs to 0. rx_pcs_valid_locked follows, since lock=0.
- Counter widths: sh_cnt holds 0..SH_CNT_MAX, sh_invalid_cnt holds 0..SH_INVALID_MAX, wait_cnt holds 0..SLIP_WAIT; each is sized by $clog2(max+1).

Decomposition:
- Shared package pcs_pkg:
  - header constants SH_DATA=2'b01, SH_CTRL=2'b10
  - lock state enum {RESET_CNT, TEST, SLIP, WAIT}
  - default SH_CNT_MAX/SH_INVALID_MAX
- One natural sub-module, pcs_sat_counter (parameterised width, increment enable, saturate). It is instantiated for rx_slip_count and rx_lock_loss_count.
- The FSM stays in pcs_block_sync.

Test Plan:
1. Reset released, 64 consecutive beats with header 2'b01 → rx_block_lock=1 exactly one cycle after the 64th beat; rx_slip never asserted; rx_slip_count=0.
2. Unlocked, header 2'b00 on beat 10 → rx_slip high for one cycle, rx_slip_count=1. The next 32 cycles of headers, including invalid ones, are ignored. Then 64 valid beats → lock=1.
3. Locked, 15 headers 2'b11 spread across one 64-beat window, repeated for 3 windows → lock stays 1, no slip, rx_lock_loss_count=0.
4. Locked, 16th invalid header falls on beat 64 of the window → lock=0 next cycle, single rx_slip pulse, rx_lock_loss_count=1, rx_slip_count incremented by 1, rx_pcs_valid_locked=0.
5. Acquisition with rx_pcs_valid toggling 1/0 every cycle → lock asserts one cycle after the 64th valid beat (about 128 cycles); idle cycles change nothing.
6. pcs_rst asserted asynchronously mid-WAIT and again while locked → rx_block_lock, rx_slip and both counts are 0 immediately. After release, a fresh 64-beat acquisition is required.
